// File: rtl/ball_pocket_tracker.sv
// rtl/ball_pocket_tracker.sv - per-frame ball/hole overlap debouncer feeding the game controller
// Optional feature macro: WHITE_RESPAWN_EN (white ball returns after RESPAWN_FRAMES frames).
module ball_pocket_tracker #(
  parameter int NUM_BALLS         = 2,
  parameter int POCKET_MIN_PIXELS = 4,
  parameter int RESPAWN_FRAMES    = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [NUM_BALLS:0] ballDrawingRequest,
  input  logic               holeDrawingRequest,
  input  logic [2:0]         holeId,
  input  logic [3:0]         stage_num,
  output logic [NUM_BALLS:0] balls_in_game,
  output logic [NUM_BALLS:0] ballhole_collide,
  output logic [2:0]         curr_Hole_id
);
  localparam int NB = NUM_BALLS + 1;
  localparam int CW = $clog2(POCKET_MIN_PIXELS + 1);
  localparam logic [CW-1:0] CMAX = CW'(POCKET_MIN_PIXELS);

  typedef enum logic [1:0] {S_RELOAD, S_COLLECT, S_REPORT} state_t;
  state_t state, nextState;

  logic [CW-1:0] cnt     [NB];
  logic [2:0]    hitHole [NB];
  logic [3:0]    stageShadow;
  logic          synced;
  logic          stageChange, frameEdge, respawn;
  logic [NB-1:0] overlap, pocket;
  logic [2:0]    lowHole;

  assign stageChange = (stage_num != stageShadow);
  assign frameEdge   = (state == S_COLLECT) && startOfFrame && !stageChange;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_RELOAD;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (stageChange) nextState = S_RELOAD;
    else begin
      case (state)
        S_RELOAD:  nextState = S_COLLECT;
        S_COLLECT: if (startOfFrame) nextState = S_REPORT;
        default:   nextState = S_COLLECT;
      endcase
    end
  end

  // Descending scan so the lowest pocketed index supplies the reported hole.
  always_comb begin
    overlap = '0;
    pocket  = '0;
    lowHole = curr_Hole_id;
    for (int i = NB - 1; i >= 0; i--) begin
      overlap[i] = (state == S_COLLECT) && balls_in_game[i] && ballDrawingRequest[i] && holeDrawingRequest;
      pocket[i]  = frameEdge && synced && (cnt[i] == CMAX);
      if (pocket[i]) lowHole = hitHole[i];
    end
  end

`ifdef WHITE_RESPAWN_EN
  localparam int RW = $clog2(RESPAWN_FRAMES + 1);
  logic [RW-1:0] respawnCnt;

  assign respawn = frameEdge && (respawnCnt == RW'(1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                respawnCnt <= '0;
    else if (state == S_RELOAD) respawnCnt <= '0;
    else if (frameEdge) begin
      if (pocket[0])            respawnCnt <= RW'(RESPAWN_FRAMES);
      else if (respawnCnt != '0) respawnCnt <= respawnCnt - RW'(1);
    end
  end
`else
  assign respawn = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      balls_in_game    <= '1;
      ballhole_collide <= '0;
      curr_Hole_id     <= '0;
      stageShadow      <= '0;
      synced           <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        cnt[i]     <= '0;
        hitHole[i] <= '0;
      end
    end else begin
      ballhole_collide <= pocket;
      stageShadow      <= stage_num;
      curr_Hole_id     <= lowHole;
      if (state == S_RELOAD) begin
        balls_in_game <= '1;
        for (int i = 0; i < NB; i++) begin
          cnt[i]     <= '0;
          hitHole[i] <= '0;
        end
      end else begin
        // The first frame boundary after reset only aligns us; that frame was partial.
        if (frameEdge) begin
          synced        <= 1'b1;
          balls_in_game <= (balls_in_game & ~pocket) | {{NUM_BALLS{1'b0}}, respawn};
        end
        for (int i = 0; i < NB; i++) begin
          if (frameEdge) begin
            cnt[i] <= overlap[i] ? CW'(1) : '0;
            if (overlap[i]) hitHole[i] <= holeId;
          end else if (overlap[i]) begin
            if (cnt[i] == '0) hitHole[i] <= holeId;
            if (cnt[i] != CMAX) cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ball_pocket_tracker.sv
// tb/tb_ball_pocket_tracker.sv - directed and random checks of ball_pocket_tracker against a frame model
module tb_ball_pocket_tracker;
  localparam int NUM_BALLS = 2;
  localparam int NB        = NUM_BALLS + 1;
  localparam int MINPIX    = 4;
  localparam int RESP      = 2;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          startOfFrame = 1'b0;
  logic [NB-1:0] ballDrawingRequest = '0;
  logic          holeDrawingRequest = 1'b0;
  logic [2:0]    holeId = '0;
  logic [3:0]    stage_num = '0;
  logic [NB-1:0] balls_in_game, ballhole_collide;
  logic [2:0]    curr_Hole_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_pocket_tracker #(
    .NUM_BALLS(NUM_BALLS), .POCKET_MIN_PIXELS(MINPIX), .RESPAWN_FRAMES(RESP)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .ballDrawingRequest(ballDrawingRequest), .holeDrawingRequest(holeDrawingRequest),
    .holeId(holeId), .stage_num(stage_num), .balls_in_game(balls_in_game),
    .ballhole_collide(ballhole_collide), .curr_Hole_id(curr_Hole_id)
  );

  // Reference: unbounded per-frame pixel counts, first hole seen per frame, and flags
  // for "this cycle is a reload" and "this cycle follows a frame boundary".
  int            mCount [NB];
  int            mFirst [NB];
  bit [NB-1:0]   mIn, mCollide;
  logic [2:0]    mHole;
  bit            mReload, mReport, mSynced;
  logic [3:0]    mShadow;
  int            mRespawn;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mIn = '1; mCollide = '0; mHole = '0;
    mReload = 1; mReport = 0; mSynced = 0; mShadow = '0; mRespawn = 0;
    for (int i = 0; i < NB; i++) begin mCount[i] = 0; mFirst[i] = -1; end
  endfunction

  function automatic void addOverlaps(input bit [NB-1:0] inGame);
    for (int i = 0; i < NB; i++)
      if (inGame[i] && ballDrawingRequest[i] && holeDrawingRequest) begin
        if (mFirst[i] < 0) mFirst[i] = int'(holeId);
        mCount[i]++;
      end
  endfunction

  function automatic void modelEdge();
    bit got;
    bit back;
    bit [NB-1:0] oldIn;
    mCollide = '0;
    if (mReload) begin
      mIn = '1; mRespawn = 0; mReport = 0;
      for (int i = 0; i < NB; i++) begin mCount[i] = 0; mFirst[i] = -1; end
      mReload = (stage_num != mShadow);
      mShadow = stage_num;
    end else if (stage_num != mShadow) begin
      mShadow = stage_num; mReload = 1; mReport = 0;
    end else if (!mReport && startOfFrame) begin
      got = 0; back = 0;
      for (int i = 0; i < NB; i++)
        if (mSynced && mCount[i] >= MINPIX) begin
          mCollide[i] = 1;
          if (!got) begin mHole = 3'(mFirst[i]); got = 1; end
        end
`ifdef WHITE_RESPAWN_EN
      if (mRespawn > 0) begin
        mRespawn--;
        if (mRespawn == 0) back = 1;
      end
      if (mCollide[0]) mRespawn = RESP;
`endif
      oldIn = mIn;
      for (int i = 0; i < NB; i++) begin mCount[i] = 0; mFirst[i] = -1; end
      addOverlaps(oldIn);
      mIn = (mIn & ~mCollide) | {{NUM_BALLS{1'b0}}, back};
      mSynced = 1; mReport = 1;
    end else begin
      if (!mReport) addOverlaps(mIn);
      mReport = 0;
    end
  endfunction

  task automatic cyc(input bit sof, input logic [NB-1:0] balls, input bit hole, input logic [2:0] hid);
    startOfFrame = sof; ballDrawingRequest = balls; holeDrawingRequest = hole; holeId = hid;
    @(posedge clk);
    modelEdge();
    #1;
    checkVal("collide", 8'(ballhole_collide), 8'(mCollide));
    checkVal("in_game", 8'(balls_in_game), 8'(mIn));
    checkVal("hole_id", 8'(curr_Hole_id), 8'(mHole));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 3'd0);
  endtask

  task automatic overlapRun(input logic [NB-1:0] balls, input logic [2:0] hid, input int n);
    repeat (n) begin
      cyc(1'b0, balls, 1'b1, hid);
      cyc(1'b0, '0, 1'b0, 3'd0);
    end
  endtask

  task automatic sofCycle();
    cyc(1'b1, '0, 1'b0, 3'd0);
  endtask

  bit            rSof, lastSof;
  bit            rHole;
  logic [NB-1:0] rBalls;

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_in_game", 8'(balls_in_game), 8'h07);
    checkVal("rst_collide", 8'(ballhole_collide), 8'h00);
    checkVal("rst_hole", 8'(curr_Hole_id), 8'h00);
    resetN = 1'b1;

    // Single pocket of ball 1 into hole 3
    idle(2); sofCycle(); idle(1);
    overlapRun(3'b010, 3'd3, 4);
    sofCycle();
    checkVal("tp1_collide", 8'(ballhole_collide), 8'h02);
    checkVal("tp1_in_game", 8'(balls_in_game), 8'h05);
    checkVal("tp1_hole", 8'(curr_Hole_id), 8'h03);
    idle(1);
    checkVal("tp1_pulse_width", 8'(ballhole_collide), 8'h00);

    // Three pixels per frame never pockets
    stage_num = 4'd1; idle(3);
    for (int f = 0; f < 5; f++) begin
      overlapRun(3'b100, 3'd4, 3);
      sofCycle();
      checkVal("tp2_no_pulse", 8'(ballhole_collide), 8'h00);
      idle(1);
    end
    checkVal("tp2_in_game", 8'(balls_in_game), 8'h07);

    // Two balls pocketed in one frame; lowest index reports its hole
    overlapRun(3'b010, 3'd5, 6);
    overlapRun(3'b100, 3'd0, 6);
    sofCycle();
    checkVal("tp3_collide", 8'(ballhole_collide), 8'h06);
    checkVal("tp3_in_game", 8'(balls_in_game), 8'h01);
    checkVal("tp3_hole", 8'(curr_Hole_id), 8'h05);
    idle(1);

    // Stage change just before the frame boundary suppresses the report
    stage_num = 4'd2; idle(3);
    overlapRun(3'b001, 3'd1, 4);
    stage_num = 4'd3; idle(1);
    sofCycle();
    checkVal("tp4_no_pulse", 8'(ballhole_collide), 8'h00);
    idle(1);
    checkVal("tp4_collide", 8'(ballhole_collide), 8'h00);
    checkVal("tp4_in_game", 8'(balls_in_game), 8'h07);

    // Overlap on the boundary cycle belongs to the new frame
    idle(2);
    cyc(1'b1, 3'b010, 1'b1, 3'd2);
    checkVal("tp5_boundary", 8'(ballhole_collide), 8'h00);
    idle(1);
    overlapRun(3'b010, 3'd6, 3);
    sofCycle();
    checkVal("tp5_collide", 8'(ballhole_collide), 8'h02);
    checkVal("tp5_hole", 8'(curr_Hole_id), 8'h02);
    idle(1);

    // Asynchronous reset mid-frame; first frame after release is partial
    overlapRun(3'b100, 3'd1, 2);
    resetN = 1'b0;
    #1;
    modelReset();
    checkVal("midrst_in_game", 8'(balls_in_game), 8'h07);
    checkVal("midrst_hole", 8'(curr_Hole_id), 8'h00);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    idle(3);
    overlapRun(3'b100, 3'd1, 4);
    sofCycle();
    checkVal("partial_frame", 8'(ballhole_collide), 8'h00);
    idle(1);
    overlapRun(3'b100, 3'd4, 4);
    sofCycle();
    checkVal("post_rst_collide", 8'(ballhole_collide), 8'h04);
    checkVal("post_rst_hole", 8'(curr_Hole_id), 8'h04);
    idle(1);

    // White ball pocket and optional respawn after RESP frames
    stage_num = 4'd4; idle(3);
    overlapRun(3'b001, 3'd7, 4);
    sofCycle();
    checkVal("white_collide", 8'(ballhole_collide), 8'h01);
    checkVal("white_in_game", 8'(balls_in_game), 8'h06);
    idle(1);
    sofCycle(); idle(1);
    sofCycle();
`ifdef WHITE_RESPAWN_EN
    checkVal("white_respawn", 8'(balls_in_game[0]), 8'h01);
`else
    checkVal("white_stays_out", 8'(balls_in_game[0]), 8'h00);
`endif
    checkVal("respawn_no_pulse", 8'(ballhole_collide[0]), 8'h00);
    idle(1);

    // Random traffic checked cycle by cycle against the model
    lastSof = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      rSof   = !lastSof && ($urandom_range(0, 39) == 0);
      rBalls = '0;
      rHole  = 1'b0;
      if (!lastSof) begin
        for (int i = 0; i < NB; i++) rBalls[i] = ($urandom_range(0, 5) == 0);
        rHole = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 399) == 0) stage_num = 4'($urandom);
      cyc(rSof, rBalls, rHole, 3'($urandom));
      lastSof = rSof;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
